// File: rtl/cbus_arbiter_pkg.sv
// Shared cbus types, burst-length encodings and arbiter constants used by
// the cache-bus arbiter and its picker.
package cbus_arbiter_pkg;

  typedef logic [2:0] msize_t;
  typedef logic [3:0] mlen_t;
  typedef logic [1:0] mburst_t;

  localparam msize_t MSIZE1 = 3'b000;
  localparam msize_t MSIZE2 = 3'b001;
  localparam msize_t MSIZE4 = 3'b010;
  localparam msize_t MSIZE8 = 3'b011;

  // len encodes beats-1
  localparam mlen_t MLEN1  = 4'b0000;
  localparam mlen_t MLEN2  = 4'b0001;
  localparam mlen_t MLEN4  = 4'b0011;
  localparam mlen_t MLEN8  = 4'b0111;
  localparam mlen_t MLEN16 = 4'b1111;

  localparam mburst_t AXI_BURST_FIXED = 2'b00;
  localparam mburst_t AXI_BURST_INCR  = 2'b01;
  localparam mburst_t AXI_BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    mburst_t     burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic {
    CBUS_ARB_IDLE = 1'b0,
    CBUS_ARB_BUSY = 1'b1
  } cbus_arb_state_t;

  // DCache at index 0, ICache at index 1 in the core instance
  localparam int CBUS_ARB_NUM_REQ = 2;

endpackage

// File: rtl/cbus_arb_picker.sv
// Combinational requester picker: first valid index found ascending from
// i_start with wrap. A start of 0 gives plain lowest-index priority.
module cbus_arb_picker
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CBUS_ARB_NUM_REQ,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_start,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0] w_cand;

  always_comb begin
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, i_start} + (IDX_W+1)'(k);
      if (w_cand >= NUM_REQ_W) begin
        w_cand = w_cand - NUM_REQ_W;
      end
      if (!o_any && i_valid[w_cand[IDX_W-1:0]]) begin
        o_any = 1'b1;
        o_idx = w_cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Cache-bus arbiter: grants one master per transaction and holds it until the
// last beat. Define CBUS_ARB_RR_EN for round-robin, else fixed priority.
//
// state | meaning
// IDLE  | no grant, outputs zero, arbitrate among valid masters
// BUSY  | winner sel owns the bus until ready && last
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CBUS_ARB_NUM_REQ,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  cbus_req_t  [NUM_REQ-1:0] ireqs,
  output cbus_resp_t [NUM_REQ-1:0] oresps,
  output cbus_req_t                oreq,
  input  cbus_resp_t               iresp
);

  cbus_arb_state_t    r_state;
  cbus_arb_state_t    w_state_nxt;
  logic [IDX_W-1:0]   r_sel;
  logic [IDX_W-1:0]   w_start;
  logic [IDX_W-1:0]   w_win;
  logic [NUM_REQ-1:0] w_valid;
  logic               w_any;
  logic               w_done;

  always_comb begin
    w_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_valid[i] = ireqs[i].valid;
    end
  end

  assign w_done = iresp.ready && iresp.last;

`ifdef CBUS_ARB_RR_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] r_rr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr <= '0;
    end else if (r_state == CBUS_ARB_BUSY && w_done) begin
      r_rr <= (r_sel == LAST_IDX) ? '0 : r_sel + 1'b1;
    end
  end

  assign w_start = r_rr;
`else
  assign w_start = '0;
`endif

  cbus_arb_picker #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_picker (
    .i_valid(w_valid),
    .i_start(w_start),
    .o_idx  (w_win),
    .o_any  (w_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CBUS_ARB_IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CBUS_ARB_IDLE && w_any) begin
        r_sel <= w_win;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CBUS_ARB_IDLE: if (w_any)  w_state_nxt = CBUS_ARB_BUSY;
      CBUS_ARB_BUSY: if (w_done) w_state_nxt = CBUS_ARB_IDLE;
      default:                   w_state_nxt = CBUS_ARB_IDLE;
    endcase
  end

  // Payload is never latched: the granted master holds it until its last beat.
  always_comb begin
    oreq   = '0;
    oresps = '0;
    if (r_state == CBUS_ARB_BUSY && !reset) begin
      oreq          = ireqs[r_sel];
      oresps[r_sel] = iresp;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter: directed scenarios plus random
// traffic, all compared every cycle against a transaction-level owner model.
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  localparam int N = CBUS_ARB_NUM_REQ;

  logic                 clk;
  logic                 reset;
  cbus_req_t  [N-1:0]   ireqs;
  cbus_resp_t [N-1:0]   oresps;
  cbus_req_t            oreq;
  cbus_resp_t           iresp;

  int checks   = 0;
  int failures = 0;

  cbus_arbiter #(.NUM_REQ(N)) dut (
    .clk   (clk),
    .reset (reset),
    .ireqs (ireqs),
    .oresps(oresps),
    .oreq  (oreq),
    .iresp (iresp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Owner model: -1 means nobody holds the bus.
  int owner = -1;
  int rr    = 0;

  function automatic int pick(input logic [N-1:0] v, input int start);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (start + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  logic [N-1:0] hs_m;
  logic         mem_hs;
  logic         mem_last;
  logic         rst_cap;

  always @(negedge clk) begin
    cbus_req_t    e_req;
    cbus_resp_t   e_resp [N];
    logic [N-1:0] v;
    e_req = '0;
    for (int i = 0; i < N; i++) e_resp[i] = '0;
    if (!reset && owner >= 0) begin
      e_req          = ireqs[owner];
      e_resp[owner]  = iresp;
    end
    chk("model_oreq", 192'(oreq), 192'(e_req));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("model_oresps%0d", i), 192'(oresps[i]), 192'(e_resp[i]));
    end
    for (int i = 0; i < N; i++) begin
      hs_m[i] = oresps[i].ready && oresps[i].last;
      v[i]    = ireqs[i].valid;
    end
    mem_hs   = iresp.ready && oreq.valid;
    mem_last = iresp.last;
    rst_cap  = reset;
    if (reset) begin
      owner = -1;
      rr    = 0;
    end else if (owner < 0) begin
`ifdef CBUS_ARB_RR_EN
      owner = pick(v, rr);
`else
      owner = pick(v, 0);
`endif
    end else if (iresp.ready && iresp.last) begin
      rr    = (owner + 1) % N;
      owner = -1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    ireqs = '0;
    iresp = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic cbus_req_t mk_req(input logic w, input logic [63:0] a, input mlen_t l,
                                       input logic [7:0] s, input logic [63:0] d);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = w;
    r.size     = MSIZE8;
    r.addr     = a;
    r.strobe   = s;
    r.data     = d;
    r.len      = l;
    r.burst    = AXI_BURST_INCR;
    return r;
  endfunction

  function automatic cbus_req_t rand_req();
    mlen_t l;
    case ($urandom_range(0, 4))
      0:       l = MLEN1;
      1:       l = MLEN2;
      2:       l = MLEN4;
      3:       l = MLEN8;
      default: l = MLEN16;
    endcase
    rand_req       = mk_req(1'($urandom), {$urandom, $urandom}, l, 8'($urandom), {$urandom, $urandom});
    rand_req.size  = 3'($urandom);
    rand_req.burst = 2'($urandom);
  endfunction

  cbus_req_t r0, r1, wr;
  int        got;
  int        exp_order [4];
  int        beat;
  logic [N-1:0] act;

  initial begin
    reset = 1'b1;
    ireqs = '0;
    iresp = '0;
`ifdef CBUS_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif

    // single request, single beat
    do_reset();
    r1 = mk_req(1'b0, 64'h0000_0000_0000_1000, MLEN1, 8'hFF, 64'h0);
    ireqs[1] = r1;
    #3 chk("t1_c0_oreq_zero", 192'(oreq), 192'(0));
    chk("t1_c0_resp1_zero", 192'(oresps[1]), 192'(0));
    step(); #3 chk("t1_c1_oreq", 192'(oreq), 192'(r1));
    step(); #3 chk("t1_c2_oreq", 192'(oreq), 192'(r1));
    step();
    iresp.ready = 1'b1; iresp.last = 1'b1; iresp.data = 64'hDEAD_BEEF_0000_1111;
    #3 chk("t1_c3_data", 192'(oresps[1].data), 192'(64'hDEAD_BEEF_0000_1111));
    chk("t1_c3_ready", 192'(oresps[1].ready), 192'(1));
    chk("t1_c3_resp0_zero", 192'(oresps[0]), 192'(0));
    step();
    iresp = '0;
    #3 chk("t1_c4_idle", 192'(oreq.valid), 192'(0));
    step(); #3 chk("t1_c5_regrant", 192'(oreq), 192'(r1));

    // simultaneous requests
    do_reset();
    r0 = mk_req(1'b0, 64'h0000_0000_0000_2000, MLEN1, 8'hFF, 64'h0);
    r1 = mk_req(1'b0, 64'h0000_0000_0000_3000, MLEN1, 8'hFF, 64'h0);
    ireqs[0] = r0; ireqs[1] = r1;
    step();
    iresp.ready = 1'b1; iresp.last = 1'b1; iresp.data = 64'h0123_4567_89AB_CDEF;
    #3 chk("t2_c1_oreq_m0", 192'(oreq), 192'(r0));
    chk("t2_c1_resp1_zero", 192'(oresps[1]), 192'(0));
    chk("t2_c1_resp0_data", 192'(oresps[0].data), 192'(64'h0123_4567_89AB_CDEF));
    step();
    ireqs[0] = '0; iresp = '0;
    #3 chk("t2_c2_idle", 192'(oreq.valid), 192'(0));
    step();
    iresp.ready = 1'b1; iresp.last = 1'b1; iresp.data = 64'h5555_AAAA_5555_AAAA;
    #3 chk("t2_c3_oreq_m1", 192'(oreq), 192'(r1));
    chk("t2_c3_resp0_zero", 192'(oresps[0]), 192'(0));
    chk("t2_c3_resp1_ready", 192'(oresps[1].ready), 192'(1));
    step();
    ireqs[1] = '0; iresp = '0;

    // grant order with both masters always requesting
    do_reset();
    ireqs[0] = r0; ireqs[1] = r1;
    for (int t = 0; t < 4; t++) begin
      got = 15;
      for (int w = 0; w < 8; w++) begin
        step(); #3;
        if (oreq.valid) begin
          got = (oreq.addr == r0.addr) ? 0 : 1;
          break;
        end
      end
      chk($sformatf("t3_grant%0d", t), 192'(got), 192'(exp_order[t]));
      step();
      iresp.ready = 1'b1; iresp.last = 1'b1; iresp.data = 64'(t);
      step();
      iresp = '0;
    end

    // burst lockout
    do_reset();
    r0 = mk_req(1'b0, 64'h0000_0000_0000_4000, MLEN16, 8'hFF, 64'h0);
    r1 = mk_req(1'b0, 64'h0000_0000_0000_5000, MLEN1, 8'hFF, 64'h0);
    ireqs[0] = r0;
    beat = 0;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 3) ireqs[1] = r1;
      iresp.ready = 1'b1; iresp.last = (c == 16); iresp.data = {$urandom, $urandom};
      #3 chk($sformatf("t4_lock_c%0d", c), 192'(oresps[1].ready), 192'(0));
      if (oresps[0].ready) beat++;
    end
    chk("t4_beats", 192'(beat), 192'(16));
    step();
    ireqs[0] = '0; iresp = '0;
    #3 chk("t4_idle", 192'(oreq.valid), 192'(0));
    step(); #3 chk("t4_m1_granted", 192'(oreq), 192'(r1));

    // write pass-through
    do_reset();
    wr = mk_req(1'b1, 64'h8000_0040, MLEN4, 8'h0F, 64'hCAFE_F00D_1234_5678);
    ireqs[1] = wr;
    for (int c = 1; c <= 8; c++) begin
      step();
      iresp.ready = (c % 2 == 0); iresp.last = (c == 8); iresp.data = 64'h0;
      #3 chk($sformatf("t5_wr_c%0d", c), 192'(oreq), 192'(wr));
    end
    step();
    ireqs[1] = '0; iresp = '0;
    #3 chk("t5_done", 192'(oreq), 192'(0));

    // reset mid-burst
    do_reset();
    r0 = mk_req(1'b0, 64'h0000_0000_0000_6000, MLEN16, 8'hFF, 64'h0);
    ireqs[0] = r0;
    for (int c = 1; c <= 4; c++) begin
      step();
      iresp.ready = 1'b1; iresp.last = 1'b0; iresp.data = {$urandom, $urandom};
    end
    step();
    reset = 1'b1;
    #3 chk("t6_c5_oreq_zero", 192'(oreq), 192'(0));
    chk("t6_c5_resp0_zero", 192'(oresps[0]), 192'(0));
    step();
    reset = 1'b0; iresp = '0;
    #3 chk("t6_c6_oreq_zero", 192'(oreq), 192'(0));
    chk("t6_c6_resp0_zero", 192'(oresps[0]), 192'(0));
    step(); #3 chk("t6_c7_fresh", 192'(oreq), 192'(r0));

    // random traffic
    do_reset();
    act  = '0;
    beat = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      for (int i = 0; i < N; i++) if (hs_m[i]) act[i] = 1'b0;
      if (mem_hs) beat = mem_last ? 0 : beat + 1;
      if (rst_cap) beat = 0;
      reset = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < N; i++) begin
        if (!act[i] && $urandom_range(0, 3) == 0) begin
          act[i]   = 1'b1;
          ireqs[i] = rand_req();
        end else if (!act[i]) begin
          ireqs[i] = '0;
        end
      end
      #1;
      iresp.data  = {$urandom, $urandom};
      iresp.ready = oreq.valid && ($urandom_range(0, 2) != 0);
      iresp.last  = iresp.ready && (beat == int'(oreq.len));
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
